dmem_responder: RTL and testbench

Data-memory responder for the pipelined MIPS core. It is the slave end of the core's `memread`/`memwrite`/`dataadr`/`writedata` interface. It services word (`lw`/`sw`) and byte (`lb`/`sb`) accesses with a programmable number of wait states, and holds the pipeline with `stall` while an access is in flight. It replaces the zero-latency data memory so the core's stall and forwarding logic can be exercised against realistic memory timing.

---
 rtl/dmem_if.sv | 23 ++
 rtl/dmem_responder.sv | 159 +++++++++++++++
 tb/tb_dmem_responder.sv | 213 +++++++++++++++++++++
 3 files changed

// File: rtl/dmem_if.sv
// Bus between the MIPS MEM stage (master) and the data-memory responder (slave).
interface dmem_if;
  logic        memread;
  logic        memwrite;
  logic        bytesel;
  logic [31:0] dataadr;
  logic [31:0] writedata;
  logic [31:0] readdata;
  logic        rdvalid;
  logic        stall;
  logic        err;
  logic [15:0] wrcount;

  modport master (
    output memread, memwrite, bytesel, dataadr, writedata,
    input  readdata, rdvalid, stall, err, wrcount
  );

  modport slave (
    input  memread, memwrite, bytesel, dataadr, writedata,
    output readdata, rdvalid, stall, err, wrcount
  );
endinterface

// File: rtl/dmem_responder.sv
// Data-memory responder with programmable wait states; stalls the core while an
// access is in flight and services word and sign-extended byte accesses.
module dmem_responder #(
  parameter int unsigned DEPTH = 64,
  parameter int unsigned WAIT  = 1
) (
  input  logic   clk,
  input  logic   reset,
  dmem_if.slave  bus
);
  localparam int unsigned AW = $clog2(DEPTH);

  typedef enum logic [1:0] {StIdle, StBusy, StDone} state_e;

  state_e        state_q, state_d;
  logic [3:0]    cnt_q, cnt_d;
  logic [AW-1:0] idx_q, idx_d;
  logic [1:0]    lane_q, lane_d;
  logic [31:0]   wdata_q, wdata_d;
  logic          bytesel_q, bytesel_d;
  logic          write_q, write_d;
  logic          mis_q, mis_d;
  logic [31:0]   readdata_q, readdata_d;
  logic          rdvalid_q, rdvalid_d;
  logic          err_q, err_d;
  logic [15:0]   wrcount_q, wrcount_d;

  logic [31:0]   mem_q [DEPTH];

  logic          req;
  logic          access;
  logic          mem_we;
  logic [31:0]   rd_word;
  logic [7:0]    rd_byte;
  logic [31:0]   rd_data;
  logic          unused_adr;

  assign req    = bus.memread | bus.memwrite;
  assign access = (state_q == StBusy) && (cnt_q == 4'd0);
  assign mem_we = access && write_q && !mis_q;

  // Addresses alias modulo 4*DEPTH.
  assign unused_adr = ^bus.dataadr[31:AW+2];

  assign rd_word = mem_q[idx_q];
  assign rd_byte = rd_word[{lane_q, 3'b000} +: 8];

  always_comb begin
    rd_data = rd_word;
    if (mis_q) begin
      rd_data = 32'd0;
    end else if (bytesel_q) begin
      rd_data = {{24{rd_byte[7]}}, rd_byte};
    end
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    idx_d      = idx_q;
    lane_d     = lane_q;
    wdata_d    = wdata_q;
    bytesel_d  = bytesel_q;
    write_d    = write_q;
    mis_d      = mis_q;
    readdata_d = readdata_q;
    rdvalid_d  = 1'b0;
    err_d      = err_q;
    wrcount_d  = wrcount_q;

    unique case (state_q)
      StIdle: begin
        if (req) begin
          state_d   = StBusy;
          cnt_d     = 4'(WAIT - 1);
          idx_d     = bus.dataadr[AW+1:2];
          lane_d    = bus.dataadr[1:0];
          wdata_d   = bus.writedata;
          bytesel_d = bus.bytesel;
          // Write wins when both strobes are set; the read is dropped.
          write_d   = bus.memwrite;
          mis_d     = !bus.bytesel && (bus.dataadr[1:0] != 2'b00);
        end
      end
      StBusy: begin
        if (cnt_q != 4'd0) begin
          cnt_d = cnt_q - 4'd1;
        end else begin
          state_d = StDone;
          if (mis_q) begin
            err_d = 1'b1;
          end
          if (write_q) begin
            if (!mis_q && (wrcount_q != 16'hFFFF)) begin
              wrcount_d = wrcount_q + 16'd1;
            end
          end else begin
            readdata_d = rd_data;
            rdvalid_d  = 1'b1;
          end
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= StIdle;
      cnt_q      <= 4'd0;
      idx_q      <= '0;
      lane_q     <= 2'd0;
      wdata_q    <= 32'd0;
      bytesel_q  <= 1'b0;
      write_q    <= 1'b0;
      mis_q      <= 1'b0;
      readdata_q <= 32'd0;
      rdvalid_q  <= 1'b0;
      err_q      <= 1'b0;
      wrcount_q  <= 16'd0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      idx_q      <= idx_d;
      lane_q     <= lane_d;
      wdata_q    <= wdata_d;
      bytesel_q  <= bytesel_d;
      write_q    <= write_d;
      mis_q      <= mis_d;
      readdata_q <= readdata_d;
      rdvalid_q  <= rdvalid_d;
      err_q      <= err_d;
      wrcount_q  <= wrcount_d;
    end
  end

  // Array is not reset; a reset during BUSY clears state_q, which kills mem_we.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      if (bytesel_q) begin
        mem_q[idx_q][{lane_q, 3'b000} +: 8] <= wdata_q[7:0];
      end else begin
        mem_q[idx_q] <= wdata_q;
      end
    end
  end

  assign bus.stall    = ((state_q == StIdle) && req) || (state_q == StBusy);
  assign bus.readdata = readdata_q;
  assign bus.rdvalid  = rdvalid_q;
  assign bus.err      = err_q;
  assign bus.wrcount  = wrcount_q;

endmodule

// File: tb/tb_dmem_responder.sv
// Randomized scoreboard bench for dmem_responder against a byte-level memory model.
module tb_dmem_responder;
  localparam int unsigned DEPTH = 64;
  localparam int unsigned WAIT  = 3;

  logic clk = 1'b0;
  logic reset;

  always #5 clk = ~clk;

  dmem_if bus ();

  dmem_responder #(
    .DEPTH (DEPTH),
    .WAIT  (WAIT)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;

  logic [31:0] model_mem [DEPTH];
  int unsigned model_wrcount;
  logic        model_err;
  logic [31:0] last_rd;
  logic [31:0] exp_q [$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] model_read(input logic bs, input logic [31:0] adr);
    logic [31:0] w;
    logic [7:0]  b;
    if (!bs && (adr % 4 != 0)) return 32'd0;
    w = model_mem[(adr / 4) % DEPTH];
    if (!bs) return w;
    b = 8'(w >> (8 * (adr % 4)));
    return {{24{b[7]}}, b};
  endfunction

  // Monitor: every rdvalid pulse must match the oldest outstanding read.
  always @(negedge clk) begin
    if (bus.rdvalid === 1'b1) begin
      if (exp_q.size() == 0) check("unexpected_rdvalid", 32'd1, 32'd0);
      else check("readdata", bus.readdata, exp_q.pop_front());
    end
  end

  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      bus.memread  = 1'b0;
      bus.memwrite = 1'b0;
      #1;
      check("stall_idle", {31'd0, bus.stall}, 32'd0);
      check("readdata_hold", bus.readdata, last_rd);
    end
  endtask

  task automatic access(input logic rd, input logic wr, input logic bs,
                        input logic [31:0] adr, input logic [31:0] wdata);
    logic mis;
    logic exp_rv;
    int   idx;
    int   lane;
    mis    = !bs && (adr % 4 != 0);
    exp_rv = rd && !wr;
    idx    = int'((adr / 4) % DEPTH);
    lane   = int'(adr % 4);
    @(negedge clk);
    bus.memread   = rd;
    bus.memwrite  = wr;
    bus.bytesel   = bs;
    bus.dataadr   = adr;
    bus.writedata = wdata;
    if (mis) model_err = 1'b1;
    if (wr) begin
      if (!mis) begin
        if (bs) model_mem[idx][8*lane +: 8] = wdata[7:0];
        else model_mem[idx] = wdata;
        if (model_wrcount < 65535) model_wrcount++;
      end
    end else begin
      last_rd = model_read(bs, adr);
      exp_q.push_back(last_rd);
    end
    #1;
    check("stall_request", {31'd0, bus.stall}, 32'd1);
    for (int k = 0; k < int'(WAIT); k++) begin
      @(negedge clk);
      #1;
      check("stall_busy", {31'd0, bus.stall}, 32'd1);
    end
    @(negedge clk);
    #1;
    check("stall_done", {31'd0, bus.stall}, 32'd0);
    check("rdvalid_done", {31'd0, bus.rdvalid}, {31'd0, exp_rv});
    check("wrcount", {16'd0, bus.wrcount}, model_wrcount);
    check("err", {31'd0, bus.err}, {31'd0, model_err});
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_readdata"}, bus.readdata, 32'd0);
    check({tag, "_rdvalid"}, {31'd0, bus.rdvalid}, 32'd0);
    check({tag, "_stall"}, {31'd0, bus.stall}, 32'd0);
    check({tag, "_err"}, {31'd0, bus.err}, 32'd0);
    check({tag, "_wrcount"}, {16'd0, bus.wrcount}, 32'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete, got timeout, expected finish");
    $fatal(1);
  end

  initial begin
    logic [31:0] adr;
    int          r;
    logic        bs;

    reset         = 1'b1;
    bus.memread   = 1'b0;
    bus.memwrite  = 1'b0;
    bus.bytesel   = 1'b0;
    bus.dataadr   = 32'd0;
    bus.writedata = 32'd0;
    model_wrcount = 0;
    model_err     = 1'b0;
    last_rd       = 32'd0;
    #1;
    check_reset_outputs("reset");
    repeat (2) @(negedge clk);
    reset = 1'b0;
    idle_cycles(2);

    for (int i = 0; i < int'(DEPTH); i++) access(1'b0, 1'b1, 1'b0, 32'(i * 4), $urandom());

    // Word round trip.
    access(1'b0, 1'b1, 1'b0, 32'h8, 32'h04EE9112);
    access(1'b1, 1'b0, 1'b0, 32'h8, 32'h0);
    idle_cycles(1);

    // Byte store/load with sign extension.
    access(1'b0, 1'b1, 1'b0, 32'h18, 32'h0);
    access(1'b0, 1'b1, 1'b1, 32'h19, 32'h123456AB);
    access(1'b1, 1'b0, 1'b0, 32'h18, 32'h0);
    access(1'b1, 1'b0, 1'b1, 32'h19, 32'h0);
    access(1'b1, 1'b0, 1'b1, 32'h18, 32'h0);
    idle_cycles(2);

    // Misaligned word store then loads.
    access(1'b0, 1'b1, 1'b0, 32'h0A, 32'h12345678);
    access(1'b1, 1'b0, 1'b0, 32'h08, 32'h0);
    access(1'b1, 1'b0, 1'b0, 32'h0A, 32'h0);

    // Simultaneous read and write: write only.
    access(1'b1, 1'b1, 1'b0, 32'h10, 32'hDEADBEEF);
    access(1'b1, 1'b0, 1'b0, 32'h10, 32'h0);

    // Address aliasing beyond 4*DEPTH.
    access(1'b0, 1'b1, 1'b0, 32'h0000_0114, 32'h5A5AC3C3);
    access(1'b1, 1'b0, 1'b0, 32'h0000_0014, 32'h0);
    access(1'b1, 1'b0, 1'b1, 32'hFFFF_FF17, 32'h0);

    // Reset pulsed during BUSY aborts a store.
    @(negedge clk);
    bus.memread   = 1'b0;
    bus.memwrite  = 1'b1;
    bus.bytesel   = 1'b0;
    bus.dataadr   = 32'h20;
    bus.writedata = 32'hCAFEF00D;
    @(negedge clk);
    #1;
    reset        = 1'b1;
    bus.memwrite = 1'b0;
    #1;
    reset = 1'b0;
    #1;
    check_reset_outputs("midreset");
    model_wrcount = 0;
    model_err     = 1'b0;
    last_rd       = 32'd0;
    idle_cycles(1);
    access(1'b1, 1'b0, 1'b0, 32'h20, 32'h0);

    // Random traffic, mostly aligned, back-to-back or with short gaps.
    for (int n = 0; n < 200; n++) begin
      r   = int'($urandom_range(0, 9));
      bs  = 1'($urandom_range(0, 1));
      adr = $urandom();
      if (!bs && ($urandom_range(0, 19) != 0)) adr[1:0] = 2'b00;
      if (r < 4) access(1'b1, 1'b0, bs, adr, $urandom());
      else if (r < 9) access(1'b0, 1'b1, bs, adr, $urandom());
      else access(1'b1, 1'b1, bs, adr, $urandom());
      idle_cycles(int'($urandom_range(0, 2)));
    end

    idle_cycles(3);
    check("pending_reads", 32'(exp_q.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
